// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID fields, register file read data, write-back port,
// EX-side control, and the registered EX-bound outputs of the pipeline register.
//   master : drives the ID/WB/EX-control side and observes the EX slot
//   slave  : the ID/EX pipeline register itself
interface id_ex_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned CNT_W  = 16
);
    // ID side
    logic              id_valid;
    logic [ADDR_W-1:0] id_rs_addr;
    logic [ADDR_W-1:0] id_rt_addr;
    logic [ADDR_W-1:0] id_rd_addr;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic [CTRL_W-1:0] id_ctrl;
    logic [DATA_W-1:0] id_imm;
    // Register file read data
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    // Write-back port
    logic              wb_regwrite;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    // EX control
    logic              ex_stall;
    logic              ex_flush;
    // Outputs
    logic              stall;
    logic              ex_valid;
    logic [ADDR_W-1:0] ex_rs_addr;
    logic [ADDR_W-1:0] ex_rt_addr;
    logic [ADDR_W-1:0] ex_rd_addr;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [DATA_W-1:0] ex_imm;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_uses_rs, id_uses_rt,
               id_ctrl, id_imm, rs_data, rt_data, wb_regwrite, wb_addr, wb_data,
               ex_stall, ex_flush,
        input  stall, ex_valid, ex_rs_addr, ex_rt_addr, ex_rd_addr, ex_ctrl, ex_imm,
               ex_rs_data, ex_rt_data, bubble_cnt
    );

    modport slave (
        input  id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_uses_rs, id_uses_rt,
               id_ctrl, id_imm, rs_data, rt_data, wb_regwrite, wb_addr, wb_data,
               ex_stall, ex_flush,
        output stall, ex_valid, ex_rs_addr, ex_rt_addr, ex_rd_addr, ex_ctrl, ex_imm,
               ex_rs_data, ex_rt_data, bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register sitting directly behind the register file.
// Captures decoded fields plus RS/RT read data, bypasses same-cycle write-back
// (the register file does not), detects load-use hazards and inserts one bubble
// per hazard, and honours EX stall/flush.
// Ports:
//   clk_i   : clock, rising edge
//   rst_n_i : asynchronous reset, active low; clears every registered output
//   bus     : id_ex_stage_if.slave -- ID fields, RF data, WB port, EX control in;
//             stall (combinational) and registered EX slot + bubble counter out
module id_ex_stage #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned CTRL_W      = 8,
    parameter int unsigned MEMREAD_BIT = 3,
    parameter int unsigned CNT_W       = 16
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    id_ex_stage_if.slave  bus
);

    logic              ex_valid_q,   ex_valid_d;
    logic [ADDR_W-1:0] ex_rs_addr_q, ex_rs_addr_d;
    logic [ADDR_W-1:0] ex_rt_addr_q, ex_rt_addr_d;
    logic [ADDR_W-1:0] ex_rd_addr_q, ex_rd_addr_d;
    logic [CTRL_W-1:0] ex_ctrl_q,    ex_ctrl_d;
    logic [DATA_W-1:0] ex_imm_q,     ex_imm_d;
    logic [DATA_W-1:0] ex_rs_data_q, ex_rs_data_d;
    logic [DATA_W-1:0] ex_rt_data_q, ex_rt_data_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    logic              wb_nz;
    logic              byp_rs, byp_rt;
    logic [DATA_W-1:0] rs_fwd, rt_fwd;
    logic              lu;

    // Write-back to r0 is architecturally discarded, so never forward it.
    assign wb_nz  = bus.wb_regwrite && (bus.wb_addr != '0);
    assign byp_rs = wb_nz && (bus.wb_addr == bus.id_rs_addr);
    assign byp_rt = wb_nz && (bus.wb_addr == bus.id_rt_addr);
    assign rs_fwd = byp_rs ? bus.wb_data : bus.rs_data;
    assign rt_fwd = byp_rt ? bus.wb_data : bus.rt_data;

    // Load in EX whose result the ID instruction needs next cycle.
    assign lu = ex_valid_q && ex_ctrl_q[MEMREAD_BIT] && (ex_rd_addr_q != '0) &&
                bus.id_valid &&
                ((bus.id_uses_rs && (bus.id_rs_addr == ex_rd_addr_q)) ||
                 (bus.id_uses_rt && (bus.id_rt_addr == ex_rd_addr_q)));

    // A flush kills the consumer, so a hazard against it must not freeze fetch.
    assign bus.stall = bus.ex_stall | (lu & ~bus.ex_flush);

    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_rs_addr_d = ex_rs_addr_q;
        ex_rt_addr_d = ex_rt_addr_q;
        ex_rd_addr_d = ex_rd_addr_q;
        ex_ctrl_d    = ex_ctrl_q;
        ex_imm_d     = ex_imm_q;
        ex_rs_data_d = ex_rs_data_q;
        ex_rt_data_d = ex_rt_data_q;
        bubble_cnt_d = bubble_cnt_q;

        if (bus.ex_flush) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
        end else if (bus.ex_stall) begin
            // Held operands would otherwise miss a write-back that retires meanwhile.
            if (wb_nz && (bus.wb_addr == ex_rs_addr_q)) begin
                ex_rs_data_d = bus.wb_data;
            end
            if (wb_nz && (bus.wb_addr == ex_rt_addr_q)) begin
                ex_rt_data_d = bus.wb_data;
            end
        end else if (lu) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
            if (bubble_cnt_q != '1) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end else begin
            ex_valid_d   = bus.id_valid;
            ex_rs_addr_d = bus.id_rs_addr;
            ex_rt_addr_d = bus.id_rt_addr;
            ex_rd_addr_d = bus.id_rd_addr;
            ex_ctrl_d    = bus.id_valid ? bus.id_ctrl : '0;
            ex_imm_d     = bus.id_imm;
            ex_rs_data_d = rs_fwd;
            ex_rt_data_d = rt_fwd;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ex_valid_q   <= 1'b0;
            ex_rs_addr_q <= '0;
            ex_rt_addr_q <= '0;
            ex_rd_addr_q <= '0;
            ex_ctrl_q    <= '0;
            ex_imm_q     <= '0;
            ex_rs_data_q <= '0;
            ex_rt_data_q <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_rs_addr_q <= ex_rs_addr_d;
            ex_rt_addr_q <= ex_rt_addr_d;
            ex_rd_addr_q <= ex_rd_addr_d;
            ex_ctrl_q    <= ex_ctrl_d;
            ex_imm_q     <= ex_imm_d;
            ex_rs_data_q <= ex_rs_data_d;
            ex_rt_data_q <= ex_rt_data_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_rs_addr = ex_rs_addr_q;
    assign bus.ex_rt_addr = ex_rt_addr_q;
    assign bus.ex_rd_addr = ex_rd_addr_q;
    assign bus.ex_ctrl    = ex_ctrl_q;
    assign bus.ex_imm     = ex_imm_q;
    assign bus.ex_rs_data = ex_rs_data_q;
    assign bus.ex_rt_data = ex_rt_data_q;
    assign bus.bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage. The bubble counter is built 8 bits wide here
// so saturation (all-ones = 0xFF) is reachable in a short run.
module tb_id_ex_stage;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned CTRL_W = 8;
    localparam int unsigned CNT_W  = 8;

    logic clk_i;
    logic rst_n_i;
    int   checks;
    int   errors;
    int   exp_bubbles;

    id_ex_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

    id_ex_stage #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W), .MEMREAD_BIT(3), .CNT_W(CNT_W)
    ) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic set_idle();
        bus.id_valid = 0; bus.id_rs_addr = 0; bus.id_rt_addr = 0; bus.id_rd_addr = 0;
        bus.id_uses_rs = 0; bus.id_uses_rt = 0; bus.id_ctrl = 0; bus.id_imm = 0;
        bus.rs_data = 0; bus.rt_data = 0; bus.wb_regwrite = 0; bus.wb_addr = 0;
        bus.wb_data = 0; bus.ex_stall = 0; bus.ex_flush = 0;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic urs, input logic urt,
                            input logic [7:0] ctrl, input logic [31:0] imm,
                            input logic [31:0] rsd, input logic [31:0] rtd);
        bus.id_valid = v; bus.id_rs_addr = rs; bus.id_rt_addr = rt; bus.id_rd_addr = rd;
        bus.id_uses_rs = urs; bus.id_uses_rt = urt; bus.id_ctrl = ctrl; bus.id_imm = imm;
        bus.rs_data = rsd; bus.rt_data = rtd;
    endtask

    // Advance one edge, land 1 time unit after it.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        drive_id(1, 5'd1, 5'd2, 5'd7, 1, 1, 8'h21, 32'h99, 32'h1, 32'h2);
        step();
        checks++; if (bus.ex_valid !== 1'b1) begin errors++;
            $display("FAIL reset_pre_valid: got %0b want 1", bus.ex_valid); end
        #1 rst_n_i = 1'b0;
        #1;
        checks++; if (bus.ex_valid !== 1'b0) begin errors++;
            $display("FAIL reset_async_valid: got %0b want 0", bus.ex_valid); end
        checks++; if (bus.ex_ctrl !== 8'h00 || bus.ex_rd_addr !== 5'd0) begin errors++;
            $display("FAIL reset_async_ctrl_rd: got %h/%0d want 00/0", bus.ex_ctrl,
                     bus.ex_rd_addr); end
        checks++; if (bus.ex_imm !== 32'h0 || bus.ex_rs_data !== 32'h0 ||
                      bus.ex_rt_data !== 32'h0) begin errors++;
            $display("FAIL reset_async_data: got %h/%h/%h want 0", bus.ex_imm,
                     bus.ex_rs_data, bus.ex_rt_data); end
        checks++; if (bus.bubble_cnt !== 8'h00) begin errors++;
            $display("FAIL reset_async_cnt: got %h want 00", bus.bubble_cnt); end
        step();
        checks++; if (bus.ex_valid !== 1'b0) begin errors++;
            $display("FAIL reset_dominates: got %0b want 0", bus.ex_valid); end
        rst_n_i = 1'b1;
        step();
        checks++; if (bus.ex_valid !== 1'b1 || bus.ex_rd_addr !== 5'd7 ||
                      bus.ex_imm !== 32'h99) begin errors++;
            $display("FAIL reset_first_capture: got v=%0b rd=%0d imm=%h want 1/7/99",
                     bus.ex_valid, bus.ex_rd_addr, bus.ex_imm); end
        set_idle();
    endtask

    task automatic test_bypass();
        drive_id(1, 5'd5, 5'd6, 5'd4, 1, 1, 8'h01, 32'h0, 32'h11, 32'h22);
        bus.wb_regwrite = 1; bus.wb_addr = 5'd5; bus.wb_data = 32'hAB;
        step();
        checks++; if (bus.ex_rs_data !== 32'hAB) begin errors++;
            $display("FAIL bypass_rs: got %h want ab", bus.ex_rs_data); end
        checks++; if (bus.ex_rt_data !== 32'h22) begin errors++;
            $display("FAIL bypass_rt_untouched: got %h want 22", bus.ex_rt_data); end
        drive_id(1, 5'd0, 5'd6, 5'd4, 1, 1, 8'h01, 32'h0, 32'h11, 32'h22);
        bus.wb_addr = 5'd0;
        step();
        checks++; if (bus.ex_rs_data !== 32'h11) begin errors++;
            $display("FAIL bypass_r0: got %h want 11", bus.ex_rs_data); end
        drive_id(1, 5'd5, 5'd7, 5'd4, 1, 1, 8'h01, 32'h0, 32'h11, 32'h33);
        bus.wb_regwrite = 1; bus.wb_addr = 5'd7; bus.wb_data = 32'hCD;
        step();
        checks++; if (bus.ex_rt_data !== 32'hCD || bus.ex_rs_data !== 32'h11) begin errors++;
            $display("FAIL bypass_rt: got rs=%h rt=%h want 11/cd", bus.ex_rs_data,
                     bus.ex_rt_data); end
        bus.wb_regwrite = 0; bus.wb_addr = 5'd5;
        step();
        checks++; if (bus.ex_rs_data !== 32'h11) begin errors++;
            $display("FAIL bypass_no_write: got %h want 11", bus.ex_rs_data); end
        set_idle();
    endtask

    task automatic test_load_use();
        drive_id(1, 5'd2, 5'd0, 5'd8, 1, 0, 8'h08, 32'h4, 32'h100, 32'h0); // lw r8
        step();
        // rt matches but is not read -> no hazard
        drive_id(1, 5'd1, 5'd8, 5'd9, 1, 0, 8'h01, 32'h0, 32'h5, 32'h6);
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++;
            $display("FAIL lu_unused_rt: got %0b want 0", bus.stall); end
        drive_id(0, 5'd1, 5'd8, 5'd9, 1, 1, 8'h01, 32'h0, 32'h5, 32'h6);
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++;
            $display("FAIL lu_invalid_id: got %0b want 0", bus.stall); end
        drive_id(1, 5'd1, 5'd8, 5'd9, 1, 1, 8'h01, 32'h0, 32'h5, 32'h6); // add r9,r1,r8
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++;
            $display("FAIL lu_stall: got %0b want 1", bus.stall); end
        step();
        if (exp_bubbles < 255) exp_bubbles++;
        checks++; if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 8'h00) begin errors++;
            $display("FAIL lu_bubble: got v=%0b ctrl=%h want 0/00", bus.ex_valid,
                     bus.ex_ctrl); end
        checks++; if (bus.bubble_cnt !== CNT_W'(exp_bubbles)) begin errors++;
            $display("FAIL lu_count: got %0d want %0d", bus.bubble_cnt, exp_bubbles); end
        checks++; if (bus.stall !== 1'b0) begin errors++;
            $display("FAIL lu_stall_release: got %0b want 0", bus.stall); end
        step();
        checks++; if (bus.ex_valid !== 1'b1 || bus.ex_rd_addr !== 5'd9 ||
                      bus.ex_ctrl !== 8'h01) begin errors++;
            $display("FAIL lu_add_enters: got v=%0b rd=%0d ctrl=%h want 1/9/01",
                     bus.ex_valid, bus.ex_rd_addr, bus.ex_ctrl); end
        set_idle();
    endtask

    task automatic test_stall_wb();
        drive_id(1, 5'd2, 5'd3, 5'd4, 1, 1, 8'h05, 32'h1234, 32'hA, 32'hB);
        step();
        bus.ex_stall = 1;
        drive_id(1, 5'd9, 5'd10, 5'd11, 1, 1, 8'h02, 32'h77, 32'hEE, 32'hFF);
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++;
            $display("FAIL stall_passthru: got %0b want 1", bus.stall); end
        step();
        bus.wb_regwrite = 1; bus.wb_addr = 5'd3; bus.wb_data = 32'h55;
        step();
        bus.wb_regwrite = 0;
        step();
        checks++; if (bus.ex_rt_data !== 32'h55) begin errors++;
            $display("FAIL stall_wb_rt: got %h want 55", bus.ex_rt_data); end
        checks++; if (bus.ex_rs_data !== 32'hA || bus.ex_rs_addr !== 5'd2 ||
                      bus.ex_rt_addr !== 5'd3 || bus.ex_rd_addr !== 5'd4) begin errors++;
            $display("FAIL stall_hold_regs: got rs=%h %0d/%0d/%0d want a 2/3/4",
                     bus.ex_rs_data, bus.ex_rs_addr, bus.ex_rt_addr, bus.ex_rd_addr); end
        checks++; if (bus.ex_imm !== 32'h1234 || bus.ex_ctrl !== 8'h05 ||
                      bus.ex_valid !== 1'b1) begin errors++;
            $display("FAIL stall_hold_misc: got imm=%h ctrl=%h v=%0b want 1234/05/1",
                     bus.ex_imm, bus.ex_ctrl, bus.ex_valid); end
        bus.ex_stall = 0;
        step();
        checks++; if (bus.ex_rd_addr !== 5'd11 || bus.ex_rs_data !== 32'hEE) begin errors++;
            $display("FAIL stall_release_capture: got rd=%0d rs=%h want 11/ee",
                     bus.ex_rd_addr, bus.ex_rs_data); end
        set_idle();
    endtask

    task automatic test_flush();
        drive_id(1, 5'd1, 5'd2, 5'd3, 1, 1, 8'h01, 32'h0, 32'h0, 32'h0);
        bus.ex_flush = 1; bus.ex_stall = 1;
        step();
        checks++; if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 8'h00) begin errors++;
            $display("FAIL flush_over_stall: got v=%0b ctrl=%h want 0/00", bus.ex_valid,
                     bus.ex_ctrl); end
        bus.ex_flush = 0; bus.ex_stall = 0;
        drive_id(1, 5'd2, 5'd0, 5'd8, 1, 0, 8'h08, 32'h4, 32'h0, 32'h0); // lw r8
        step();
        drive_id(1, 5'd8, 5'd1, 5'd9, 1, 1, 8'h01, 32'h0, 32'h0, 32'h0);
        bus.ex_flush = 1;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++;
            $display("FAIL flush_lu_stall: got %0b want 0", bus.stall); end
        step();
        checks++; if (bus.bubble_cnt !== CNT_W'(exp_bubbles) || bus.ex_valid !== 1'b0)
            begin errors++;
            $display("FAIL flush_lu_count: got cnt=%0d v=%0b want %0d/0", bus.bubble_cnt,
                     bus.ex_valid, exp_bubbles); end
        set_idle();
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) begin
            drive_id(1, 5'd2, 5'd0, 5'd8, 1, 0, 8'h08, 32'h0, 32'h0, 32'h0);
            step();
            drive_id(1, 5'd1, 5'd8, 5'd9, 1, 1, 8'h01, 32'h0, 32'h0, 32'h0);
            step();
            if (exp_bubbles < 255) exp_bubbles++;
            if (exp_bubbles == 255) break;
        end
        checks++; if (bus.bubble_cnt !== 8'hFF) begin errors++;
            $display("FAIL sat_reach: got %h want ff", bus.bubble_cnt); end
        drive_id(1, 5'd2, 5'd0, 5'd8, 1, 0, 8'h08, 32'h0, 32'h0, 32'h0);
        step();
        drive_id(1, 5'd1, 5'd8, 5'd9, 1, 1, 8'h01, 32'h0, 32'h0, 32'h0);
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++;
            $display("FAIL sat_hazard_seen: got %0b want 1", bus.stall); end
        step();
        checks++; if (bus.bubble_cnt !== 8'hFF || bus.ex_valid !== 1'b0) begin errors++;
            $display("FAIL sat_hold: got cnt=%h v=%0b want ff/0", bus.bubble_cnt,
                     bus.ex_valid); end
        set_idle();
        #1 rst_n_i = 1'b0;
        #1;
        checks++; if (bus.bubble_cnt !== 8'h00) begin errors++;
            $display("FAIL sat_reset_clear: got %h want 00", bus.bubble_cnt); end
        rst_n_i = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_bubbles = 0;
        set_idle();
        rst_n_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        test_reset();
        test_bypass();
        test_load_use();
        test_stall_wb();
        test_flush();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so a broken design can never hang the run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "timeout");
    end
endmodule
